// File: rtl/led_pattern_if.sv
// LED pattern engine control/status bundle.
// Signals: en, step, mode, load, load_value (controller -> engine);
//          leds, dir, tick (engine -> controller / LED pins).
// The master modport is the controlling side; the slave modport is the engine.
interface led_pattern_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             step;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] leds;
    logic             dir;
    logic             tick;

    modport master (
        output en, step, mode, load, load_value,
        input  leds, dir, tick
    );

    modport slave (
        input  en, step, mode, load, load_value,
        output leds, dir, tick
    );
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern generator: a free-running prescaler advances a WIDTH-bit pattern
// once every DIV enabled clocks (or once per step request while paused), using
// one of four modes: rotate left, rotate right, bounce, fill/empty.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus.en     prescaler run enable
//   bus.step   single advance request, honoured only while en=0
//   bus.mode   0 rotl, 1 rotr, 2 bounce, 3 fill/empty
//   bus.load   synchronous load of bus.load_value
//   bus.leds   registered pattern
//   bus.dir    registered direction/phase bit
//   bus.tick   registered one-cycle pulse after each advance
module led_pattern_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 25_000_000,
    parameter logic [7:0]  INIT  = 8'b0001_1111
) (
    input  logic         clk,
    input  logic         rst,
    led_pattern_if.slave bus
);

    localparam int unsigned      CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [WIDTH-1:0] INIT_W  = WIDTH'(INIT);

    logic [WIDTH-1:0] leds_q, leds_d;
    logic             dir_q, dir_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;

    logic             wrap;
    logic             advance;
    logic             dir_cur;
    logic [WIDTH-1:0] nxt_pat;
    logic             nxt_dir;

    // A mode change this cycle restarts the direction/phase from 0.
    assign dir_cur = (bus.mode != mode_q) ? 1'b0 : dir_q;

    assign wrap    = bus.en && (cnt_q == CNT_MAX);
    assign advance = wrap || (!bus.en && bus.step);

    // Next pattern and direction for one advance in the current mode.
    always_comb begin
        nxt_pat = leds_q;
        nxt_dir = dir_cur;
        case (bus.mode)
            2'd0: begin
                nxt_pat = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
                nxt_dir = 1'b0;
            end
            2'd1: begin
                nxt_pat = {leds_q[0], leds_q[WIDTH-1:1]};
                nxt_dir = 1'b0;
            end
            2'd2: begin
                // Both ends lit: nothing can move, so only the direction flips.
                if (leds_q[WIDTH-1] && leds_q[0]) begin
                    nxt_dir = ~dir_cur;
                end else if (!dir_cur && leds_q[WIDTH-1]) begin
                    nxt_dir = 1'b1;
                    nxt_pat = {1'b0, leds_q[WIDTH-1:1]};
                end else if (dir_cur && leds_q[0]) begin
                    nxt_dir = 1'b0;
                    nxt_pat = {leds_q[WIDTH-2:0], 1'b0};
                end else if (dir_cur) begin
                    nxt_pat = {1'b0, leds_q[WIDTH-1:1]};
                end else begin
                    nxt_pat = {leds_q[WIDTH-2:0], 1'b0};
                end
            end
            default: begin
                // Phase flips as the shift-in produces an all-ones / all-zeros pattern.
                if (!dir_cur) begin
                    nxt_pat = {leds_q[WIDTH-2:0], 1'b1};
                    if (&leds_q[WIDTH-2:0]) begin
                        nxt_dir = 1'b1;
                    end
                end else begin
                    nxt_pat = {leds_q[WIDTH-2:0], 1'b0};
                    if (leds_q[WIDTH-2:0] == '0) begin
                        nxt_dir = 1'b0;
                    end
                end
            end
        endcase
    end

    // Load beats advance; prescaler only moves while enabled.
    always_comb begin
        leds_d = leds_q;
        dir_d  = dir_cur;
        tick_d = 1'b0;
        cnt_d  = cnt_q;
        mode_d = bus.mode;
        if (bus.load) begin
            leds_d = bus.load_value;
            cnt_d  = '0;
            dir_d  = 1'b0;
        end else begin
            if (bus.en) begin
                cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            end
            if (advance) begin
                leds_d = nxt_pat;
                dir_d  = nxt_dir;
                tick_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q <= INIT_W;
            dir_q  <= 1'b0;
            tick_q <= 1'b0;
            cnt_q  <= '0;
            mode_q <= bus.mode;
        end else begin
            leds_q <= leds_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign bus.leds = leds_q;
    assign bus.dir  = dir_q;
    assign bus.tick = tick_q;

endmodule
